// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, CON bit positions and TX FSM states for the UART MMIO block
package uart_mmio_pkg;
    localparam logic [31:0] TXD_OFF = 32'd0;
    localparam logic [31:0] RXD_OFF = 32'd4;
    localparam logic [31:0] CON_OFF = 32'd8;
    localparam int CON_TX_BUSY     = 0;
    localparam int CON_HOLD_FULL   = 1;
    localparam int CON_RX_NONEMPTY = 2;
    localparam int CON_RX_FULL     = 3;
    localparam int CON_RX_OVF      = 4;
    localparam int CON_TX_OVF      = 5;
    localparam int CON_IE          = 8;
    typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_WAIT_LO, TX_WAIT_HI} tx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: power-of-two byte FIFO; a pop frees a slot for a push in the same cycle, refused pushes raise drop
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       drop
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign head  = mem_q[rd_q];
    // accept a push when a slot is free now or is freed by a pop on this edge
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        drop    = push & ~do_push;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // storage and pointer registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: CPU-bus UART controller (RX FIFO, one-deep TX holding, sender handshake); UART_MMIO_IRQ_EN adds ie/irq
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
    parameter int          RX_DEPTH  = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status,
    output logic        irq
);
    tx_state_e   state_q, state_d;
    logic [1:0]  rx_sync_q, rx_sync_d, tx_sync_q, tx_sync_d;
    logic        rx_prev_q, rx_prev_d;
    logic [7:0]  tx_data_q, tx_data_d, hold_q, hold_d;
    logic        hold_full_q, hold_full_d, rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic        ie_q, irq_q, tx_ovf_set, tx_sync, rx_rise;
    logic        hit_txd, hit_rxd, hit_con, wr_txd, rd_rxd, wr_con;
    logic [7:0]  rx_head;
    logic        rx_full, rx_empty, rx_drop;
    logic [31:0] con;
    logic        unused_wdata;
    assign unused_wdata = ^wdata;
    assign hit_txd = addr == BASE_ADDR + TXD_OFF;
    assign hit_rxd = addr == BASE_ADDR + RXD_OFF;
    assign hit_con = addr == BASE_ADDR + CON_OFF;
    assign wr_txd  = MemWrite & hit_txd;
    assign rd_rxd  = MemRead & hit_rxd;
    assign wr_con  = MemWrite & hit_con;
    assign tx_sync = tx_sync_q[1];
    assign rx_rise = rx_sync_q[1] & ~rx_prev_q;
    assign tx_data = tx_data_q;
    assign irq     = irq_q;

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
        .sysclk(sysclk), .reset(reset), .push(rx_rise), .pop(rd_rxd), .din(rx_data),
        .head(rx_head), .full(rx_full), .empty(rx_empty), .drop(rx_drop)
    );

    // synchronizers, RX edge detect and sticky overflow flags (a same-cycle set beats the clear)
    always_comb begin
        rx_sync_d = {rx_sync_q[0], rx_status};
        tx_sync_d = {tx_sync_q[0], tx_status};
        rx_prev_d = rx_sync_q[1];
        rx_ovf_d  = (rx_ovf_q & ~(wr_con & wdata[CON_RX_OVF])) | rx_drop;
        tx_ovf_d  = (tx_ovf_q & ~(wr_con & wdata[CON_TX_OVF])) | tx_ovf_set;
    end

    // TX FSM: launch a byte, wait for the sender to go busy then idle, chain the holding byte
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_ovf_set  = 1'b0;
        tx_en       = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (hold_full_q) begin
                    tx_data_d   = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = TX_LAUNCH;
                end else if (wr_txd) begin
                    tx_data_d = wdata[7:0];
                    state_d   = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                tx_en   = 1'b1;
                state_d = TX_WAIT_LO;
            end
            TX_WAIT_LO: state_d = tx_sync ? TX_WAIT_LO : TX_WAIT_HI;
            TX_WAIT_HI: begin
                if (tx_sync && hold_full_q) begin
                    tx_data_d   = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = TX_LAUNCH;
                end else if (tx_sync) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (wr_txd && (state_q != TX_IDLE || hold_full_q)) begin
            if (hold_full_q) begin
                tx_ovf_set = 1'b1;
            end else begin
                hold_d      = wdata[7:0];
                hold_full_d = 1'b1;
            end
        end
    end

    // status register and read-data mux
    always_comb begin
        con                  = '0;
        con[CON_TX_BUSY]     = state_q != TX_IDLE;
        con[CON_HOLD_FULL]   = hold_full_q;
        con[CON_RX_NONEMPTY] = ~rx_empty;
        con[CON_RX_FULL]     = rx_full;
        con[CON_RX_OVF]      = rx_ovf_q;
        con[CON_TX_OVF]      = tx_ovf_q;
        con[CON_IE]          = ie_q;
        rdata = hit_txd ? {24'b0, tx_data_q} :
                hit_rxd ? {24'b0, rx_empty ? 8'h00 : rx_head} :
                hit_con ? con : 32'b0;
    end

    // core state registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= TX_IDLE;
            rx_sync_q   <= '0;
            tx_sync_q   <= '0;
            rx_prev_q   <= 1'b0;
            tx_data_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_sync_q   <= rx_sync_d;
            tx_sync_q   <= tx_sync_d;
            rx_prev_q   <= rx_prev_d;
            tx_data_q   <= tx_data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
        end
    end

`ifdef UART_MMIO_IRQ_EN
    logic ie_d, irq_d;
    // interrupt enable and registered request
    always_comb begin
        ie_d  = wr_con ? wdata[CON_IE] : ie_q;
        irq_d = ie_q & (~rx_empty | rx_ovf_q);
    end
    // interrupt registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end
`else
    assign ie_q  = 1'b0;
    assign irq_q = 1'b0;
`endif
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio with a sender model; checks irq path when UART_MMIO_IRQ_EN is set
module tb_uart_mmio;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [7:0]  rx_data = '0, tx_data;
    logic        rx_status = 1'b0, tx_status = 1'b1, tx_en, irq;

    int         compared = 0, mismatched = 0, pulses = 0, snd_cnt = 0;
    bit         irq_seen = 1'b0;
    logic [7:0] tx_exp[$], rx_exp[$];
    logic [7:0] snd_e;

    uart_mmio dut (
        .sysclk(sysclk), .reset(reset), .addr(addr), .wdata(wdata), .MemRead(MemRead),
        .MemWrite(MemWrite), .rdata(rdata), .rx_data(rx_data), .rx_status(rx_status),
        .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    // sender model: goes busy 2 cycles after tx_en, idle 100 cycles later; checks each launched byte
    always @(negedge sysclk) begin
        if (!reset) begin
            snd_cnt   = 0;
            tx_status = 1'b1;
        end else begin
            if (tx_en === 1'b1) begin
                pulses++;
                compared++;
                if (tx_exp.size() == 0) begin
                    mismatched++;
                    $display("FAIL tx_byte: sent %h, expected nothing", tx_data);
                end else begin
                    snd_e = tx_exp.pop_front();
                    if (tx_data !== snd_e) begin
                        mismatched++;
                        $display("FAIL tx_byte: sent %h, expected %h", tx_data, snd_e);
                    end
                end
                snd_cnt = 1;
            end else if (snd_cnt > 0) begin
                snd_cnt++;
            end
            if (snd_cnt == 3) tx_status = 1'b0;
            if (snd_cnt == 103) begin
                tx_status = 1'b1;
                snd_cnt   = 0;
            end
        end
    end

`ifndef UART_MMIO_IRQ_EN
    always @(negedge sysclk) if (irq !== 1'b0) irq_seen = 1'b1;
`endif

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWrite = 1'b1;
        @(negedge sysclk);
        MemWrite = 1'b0; addr = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; MemRead = 1'b1;
        #1 d = rdata;
        @(negedge sysclk);
        MemRead = 1'b0; addr = '0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b; rx_status = 1'b1;
        repeat (4) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    task automatic wait_idle(output logic [31:0] d);
        d = 32'h1;
        for (int i = 0; i < 600 && d[0]; i++) rd(CON, d);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        repeat (3) @(negedge sysclk);
        compared += 3;
        if (tx_en !== 1'b0) begin mismatched++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        if (irq !== 1'b0) begin mismatched++; $display("FAIL reset_irq: got %b want 0", irq); end
        if (tx_data !== 8'h00) begin mismatched++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        reset = 1'b1;
        @(negedge sysclk);
        rd(CON, d);
        compared++;
        if (d !== 32'h0) begin mismatched++; $display("FAIL reset_con: got %h want 0", d); end
    endtask

    task automatic test_tx_single;
        logic [31:0] d;
        int p0 = pulses;
        tx_exp.push_back(8'h41);
        wr(TXD, 32'h41);
        repeat (10) @(negedge sysclk);
        rd(CON, d);
        compared += 2;
        if (d !== 32'h1) begin mismatched++; $display("FAIL tx_busy_con: got %h want 1", d); end
        if (tx_data !== 8'h41) begin mismatched++; $display("FAIL tx_data_hold: got %h want 41", tx_data); end
        wait_idle(d);
        compared += 2;
        if (d !== 32'h0) begin mismatched++; $display("FAIL tx_idle_con: got %h want 0", d); end
        if (pulses - p0 !== 1) begin mismatched++; $display("FAIL tx_pulses: got %0d want 1", pulses - p0); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        int p0 = pulses;
        tx_exp.push_back(8'h11);
        tx_exp.push_back(8'h22);
        wr(TXD, 32'h11);
        wr(TXD, 32'h22);
        wr(TXD, 32'h33);
        rd(CON, d);
        compared++;
        if (d !== 32'h23) begin mismatched++; $display("FAIL b2b_busy_con: got %h want 23", d); end
        wait_idle(d);
        compared += 2;
        if (d !== 32'h20) begin mismatched++; $display("FAIL b2b_con_ovf: got %h want 20", d); end
        if (pulses - p0 !== 2) begin mismatched++; $display("FAIL b2b_pulses: got %0d want 2", pulses - p0); end
        wr(CON, 32'h20);
        rd(CON, d);
        compared++;
        if (d !== 32'h0) begin mismatched++; $display("FAIL b2b_w1c: got %h want 0", d); end
    endtask

    task automatic test_misc;
        logic [31:0] d;
        rd(CON + 32'd4, d);
        compared++;
        if (d !== 32'h0) begin mismatched++; $display("FAIL miss_read: got %h want 0", d); end
        wr(CON + 32'd4, 32'hFFFF_FFFF);
        rd(CON, d);
        compared++;
        if (d !== 32'h0) begin mismatched++; $display("FAIL miss_write_con: got %h want 0", d); end
        rd(TXD, d);
        compared++;
        if (d !== 32'h22) begin mismatched++; $display("FAIL txd_read: got %h want 22", d); end
    endtask

    task automatic test_rx_overflow;
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 0; i < 5; i++) begin
            e = 8'hA0 + 8'(i);
            if (i < 4) rx_exp.push_back(e);
            rx_byte(e);
        end
        rd(CON, d);
        compared++;
        if (d !== 32'h1C) begin mismatched++; $display("FAIL rx_ovf_con: got %h want 1c", d); end
        for (int i = 0; i < 4; i++) begin
            rd(RXD, d);
            e = rx_exp.pop_front();
            compared++;
            if (d !== {24'b0, e}) begin mismatched++; $display("FAIL rx_read%0d: got %h want %h", i, d, e); end
        end
        rd(RXD, d);
        compared++;
        if (d !== 32'h0) begin mismatched++; $display("FAIL rx_read_empty: got %h want 0", d); end
        rd(CON, d);
        compared++;
        if (d !== 32'h10) begin mismatched++; $display("FAIL rx_ovf_sticky: got %h want 10", d); end
        wr(CON, 32'h10);
        rd(CON, d);
        compared++;
        if (d !== 32'h0) begin mismatched++; $display("FAIL rx_ovf_w1c: got %h want 0", d); end
    endtask

    task automatic test_push_pop_full;
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 0; i < 4; i++) begin
            e = 8'hB0 + 8'(i);
            rx_exp.push_back(e);
            rx_byte(e);
        end
        rx_data = 8'hB4;
        rx_status = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        rx_exp.push_back(8'hB4);
        rd(RXD, d);
        e = rx_exp.pop_front();
        compared++;
        if (d !== {24'b0, e}) begin mismatched++; $display("FAIL pp_read: got %h want %h", d, e); end
        rx_status = 1'b0;
        repeat (3) @(negedge sysclk);
        rd(CON, d);
        compared++;
        if (d !== 32'h0C) begin mismatched++; $display("FAIL pp_con: got %h want 0c", d); end
        for (int i = 0; i < 4; i++) begin
            rd(RXD, d);
            e = rx_exp.pop_front();
            compared++;
            if (d !== {24'b0, e}) begin mismatched++; $display("FAIL pp_drain%0d: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        int p0 = pulses;
        tx_exp.push_back(8'h5C);
        wr(TXD, 32'h5C);
        repeat (5) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        compared++;
        if (tx_data !== 8'h00) begin mismatched++; $display("FAIL mid_reset_tx_data: got %h want 00", tx_data); end
        reset = 1'b1;
        repeat (150) @(negedge sysclk);
        rd(CON, d);
        compared += 2;
        if (pulses - p0 !== 1) begin mismatched++; $display("FAIL mid_reset_pulses: got %0d want 1", pulses - p0); end
        if (d !== 32'h0) begin mismatched++; $display("FAIL mid_reset_con: got %h want 0", d); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        wr(CON, 32'h100);
        rx_byte(8'h5A);
`ifdef UART_MMIO_IRQ_EN
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("FAIL irq_set: got %b want 1", irq); end
        rd(RXD, d);
        compared++;
        if (d !== 32'h5A) begin mismatched++; $display("FAIL irq_rxd: got %h want 5a", d); end
        @(negedge sysclk);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("FAIL irq_fall: got %b want 0", irq); end
        rd(CON, d);
        compared++;
        if (d !== 32'h100) begin mismatched++; $display("FAIL irq_con_ie: got %h want 100", d); end
`else
        rd(CON, d);
        compared++;
        if (d !== 32'h04) begin mismatched++; $display("FAIL noirq_con: got %h want 04", d); end
        rd(RXD, d);
        compared++;
        if (d !== 32'h5A) begin mismatched++; $display("FAIL noirq_rxd: got %h want 5a", d); end
        compared++;
        if (irq_seen !== 1'b0) begin mismatched++; $display("FAIL noirq_irq: got 1 want 0"); end
`endif
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_misc();
        test_rx_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_irq();
        compared++;
        if (tx_exp.size() != 0) begin mismatched++; $display("FAIL tx_leftover: got %0d bytes want 0", tx_exp.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped UART controller for the single-cycle MIPS core. It sits between the CPU data-memory bus and the byte-level UART receiver/sender pair.
- Consumes received bytes from the receiver into a small RX FIFO.
- Feeds CPU-written bytes to the sender through a one-deep holding register.
- Generates the sender's start pulse and exposes status/control registers plus an optional interrupt.

Parameters:
BASE_ADDR, 32'h4000_0018, byte address of TXD register; RXD = BASE+4, CON = BASE+8
RX_DEPTH, 4, RX FIFO entries (power of two, >=2)

Ports:
sysclk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
addr  in  32  CPU byte address
wdata  in  32  CPU write data
MemRead  in  1  CPU read strobe
MemWrite  in  1  CPU write strobe
rdata  out  32  read data, combinational from addr/state, 0 when no register hit
rx_data  in  8  byte from receiver, stable while rx_status high
rx_status  in  1  receiver byte-valid level (asynchronous to sysclk)
tx_data  out  8  byte to sender, held stable until transmit completes
tx_en  out  1  sender start pulse, exactly one sysclk cycle
tx_status  in  1  sender idle level (1 idle, 0 busy; asynchronous to sysclk)
irq  out  1  interrupt request

Behaviour:
- Reset (asynchronous, active-low) clears all state. Reset values: tx_data=0, tx_en=0, irq=0, FIFO empty, holding empty, sticky flags=0, ie=0, TX FSM=IDLE.
- Reset asserted mid-transfer aborts the transfer; no tx_en is issued afterwards.
- rx_status and tx_status each pass through a 2-FF synchronizer before use.
- RX path:
  - A rising edge of synchronized rx_status pushes rx_data into the FIFO, 3 cycles after the raw edge.
  - Push while FIFO full: byte dropped, rx_ovf set.
  - Push and pop in the same cycle while full: both occur, no overflow.
- RXD read (MemRead, addr==BASE+4):
  - rdata={24'b0, head byte} in the same cycle; pop on that clock edge.
  - Read while empty returns 0 and changes nothing.
- TX FSM states: IDLE, LAUNCH, WAIT_LO, WAIT_HI.
  - IDLE: a TXD write (MemWrite, addr==BASE) loads tx_data=wdata[7:0] and goes to LAUNCH.
  - LAUNCH: tx_en=1 for this single cycle, then WAIT_LO.
  - WAIT_LO: waits for synced tx_status==0, then WAIT_HI.
  - WAIT_HI: on synced tx_status==1, if holding full, moves the byte to tx_data, clears holding and goes to LAUNCH; otherwise goes to IDLE.
- TXD write when FSM not IDLE:
  - If holding empty, the byte goes to holding.
  - If holding full, the write is dropped and tx_ovf set.
- CON read: bit0 tx_busy (FSM!=IDLE), bit1 hold_full, bit2 rx_nonempty, bit3 rx_full, bit4 rx_ovf, bit5 tx_ovf, bit8 ie; other bits 0.
- CON write:
  - Writing 1 to bit4/bit5 clears that flag (write-1-to-clear).
  - bit8 writes ie.
  - A flag set and cleared in the same cycle ends set.
- MemRead and MemWrite to non-matching addresses have no effect. A TXD read returns the current tx_data zero-extended.

Optional Feature:
UART_MMIO_IRQ_EN
- Defined: irq = ie & (rx_nonempty | rx_ovf), registered with one cycle of latency.
- Undefined: irq tied 0, ie not implemented, CON bit8 reads 0 and writes to it are ignored.

Decomposition:
- Package uart_mmio_pkg holds:
  - register offsets: TXD_OFF=0, RXD_OFF=4, CON_OFF=8
  - CON bit-index constants
  - TX FSM state enum
- One sub-module, uart_rx_fifo: parameterised depth, push/pop, full/empty, head output, simultaneous push/pop support.

Test Plan:
- Reset, then read CON -> rdata=0; tx_en=0, irq=0.
- Write TXD=0x41; sender model drops tx_status low 2 cycles after tx_en and raises it 100 cycles later -> one tx_en pulse, tx_data=0x41, CON bit0 reads 1 during transfer and 0 after.
- Three TXD writes 0x11, 0x22, 0x33 back-to-back -> 0x11 and 0x22 transmitted in order; 0x33 dropped; CON=0x20 after completion; writing CON=0x20 clears it to 0.
- Five rx_status pulses with bytes 0xA0..0xA4, RX_DEPTH=4 -> CON bits 2, 3 and 4 set; four RXD reads return 0xA0..0xA3; a fifth read returns 0.
- With FIFO full, push and RXD read in the same cycle -> no overflow flag; subsequent reads return remaining bytes in order.
- With UART_MMIO_IRQ_EN: set ie, receive 0x5A -> irq=1; RXD read returns 0x5A and irq falls the next cycle. Without the macro, irq stays 0 throughout.
